sequence_extractor: RTL and testbench

Receive-side counterpart of the sequence generator. It sits on the 10-bit 4:2:2 sample stream from the TVP5147 decoder interface and recovers the 40-bit frame (8-bit identifier + 32-bit sequence) embedded as black/white luma levels in one marked line of 1440 samples. Each bit occupies 36 samples (18 luma). The block majority-votes each bit cell, checks the identifier, and publishes the 32-bit sequence to the descrambler.

---
 rtl/sequence_extractor.sv | 134 +++++++++++++
 tb/tb_sequence_extractor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sequence_extractor.sv
// Recovers the 40-bit identifier+sequence frame embedded as luma levels in one
// marked video line, majority-votes each bit cell and publishes the sequence.
module sequence_extractor #(
  parameter logic [9:0] THRESHOLD       = 10'h1F6,
  parameter logic [7:0] ID              = 8'hA5,
  parameter int         SAMPLES_PER_BIT = 36,
  parameter int         NUM_BITS        = 40,
  parameter int         VOTE_MIN        = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [9:0]  sample_in,
  output logic [31:0] sequence_out,
  output logic [7:0]  id_out,
  output logic        valid,
  output logic        id_error,
  output logic        busy
);

  // state    | meaning
  // IDLE     | waiting for enable; its first high edge is sample index 0
  // CAPTURE  | slicing luma, voting per cell, shifting decided bits
  // CHECK    | compare identifier, publish sequence or flag id_error
  // WAIT_LOW | line already consumed; wait for enable to drop
  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, WAIT_LOW} state_t;

  localparam logic [5:0] LAST_CELL = 6'(SAMPLES_PER_BIT - 1);
  localparam logic [5:0] LAST_BIT  = 6'(NUM_BITS - 1);
  localparam logic [4:0] VOTE_THR  = 5'(VOTE_MIN);

  state_t                state_q, state_d;
  logic [5:0]            cell_q, cell_d;
  logic [4:0]            vote_q, vote_d;
  logic [5:0]            bit_q, bit_d;
  logic [NUM_BITS-1:0]   shreg_q, shreg_d;
  logic [31:0]           seq_q, seq_d;
  logic [7:0]            id_q, id_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic                  luma_hit;
  logic [4:0]            vote_sum;
  logic                  bit_val;

  assign luma_hit = (sample_in > THRESHOLD);
  assign vote_sum = vote_q + {4'b0, luma_hit};
  assign bit_val  = (vote_sum >= VOTE_THR);

  always_comb begin
    state_d = state_q;
    cell_d  = cell_q;
    vote_d  = vote_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    seq_d   = seq_q;
    id_d    = id_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          // Index 0 (chroma) is consumed on this edge, so the next sample is index 1.
          cell_d  = 6'd1;
          vote_d  = '0;
          bit_d   = '0;
          shreg_d = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          if (cell_q[0]) vote_d = vote_sum;
          if (cell_q == LAST_CELL) begin
            cell_d  = '0;
            vote_d  = '0;
            bit_d   = bit_q + 6'd1;
            shreg_d = {shreg_q[NUM_BITS-2:0], bit_val};
            if (bit_q == LAST_BIT) state_d = CHECK;
          end else begin
            cell_d = cell_q + 6'd1;
          end
        end
      end
      CHECK: begin
        id_d = shreg_q[NUM_BITS-1 -: 8];
        if (shreg_q[NUM_BITS-1 -: 8] == ID) begin
          seq_d   = shreg_q[31:0];
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cell_q  <= '0;
      vote_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      seq_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      vote_q  <= vote_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      seq_q   <= seq_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign sequence_out = seq_q;
  assign id_out       = id_q;
  assign valid        = valid_q;
  assign id_error     = err_q;
  assign busy         = (state_q == CAPTURE) || (state_q == CHECK);

endmodule

// File: tb/tb_sequence_extractor.sv
// Directed bench for sequence_extractor: builds carrier lines sample by sample
// and checks pulses, decoded values and abort/reset behaviour.
module tb_sequence_extractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [9:0]  sample_in;
  logic [31:0] sequence_out;
  logic [7:0]  id_out;
  logic        valid;
  logic        id_error;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic        pre_busy, pre_pulse, post_pulse;
  logic        cap_valid, cap_err, cap_busy;
  logic [31:0] cap_seq;
  logic [7:0]  cap_id;

  sequence_extractor dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in),
    .sequence_out(sequence_out), .id_out(id_out), .valid(valid),
    .id_error(id_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // f1: luma samples forced low in 1-cells; f0: luma samples forced high in 0-cells.
  function automatic logic [9:0] sample_val(input logic [39:0] frame, input int i,
                                            input int f1, input int f0,
                                            input logic [9:0] chroma, input logic [9:0] lo);
    logic [39:0] f;
    int k;
    logic b;
    f = frame;
    if (i >= 1440) return 10'h3AC;
    if ((i % 2) == 0) return chroma;
    k = (i % 36) / 2;
    b = f[39 - (i / 36)];
    if (b) return (k < f1) ? 10'h040 : 10'h3AC;
    return (k < f0) ? 10'h3AC : lo;
  endfunction

  task automatic send_line(input logic [39:0] frame, input int f1, input int f0,
                           input logic [9:0] chroma, input logic [9:0] lo, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enable    = 1'b1;
      sample_in = sample_val(frame, i, f1, f0, chroma, lo);
    end
  endtask

  // Captures the state after E1439, after E1440 and after E1441, then lets the FSM return to IDLE.
  task automatic finish_line();
    @(negedge clk);
    pre_busy  = busy;
    pre_pulse = valid | id_error;
    enable    = 1'b0;
    sample_in = 10'h000;
    @(negedge clk);
    cap_valid = valid;
    cap_err   = id_error;
    cap_busy  = busy;
    cap_seq   = sequence_out;
    cap_id    = id_out;
    @(negedge clk);
    post_pulse = valid | id_error;
    @(negedge clk);
  endtask

  task automatic test_reset();
    vectors++; if (sequence_out !== 32'h0) begin miscompares++; $display("FAIL reset_seq got %h want 00000000", sequence_out); end
    vectors++; if (id_out !== 8'h00) begin miscompares++; $display("FAIL reset_id got %h want 00", id_out); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid); end
    vectors++; if (id_error !== 1'b0) begin miscompares++; $display("FAIL reset_id_error got %b want 0", id_error); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_ideal();
    send_line({8'hA5, 32'hDEADBEEF}, 0, 0, 10'h200, 10'h040, 1440);
    finish_line();
    vectors++; if (pre_busy !== 1'b1) begin miscompares++; $display("FAIL ideal_busy_e1439 got %b want 1", pre_busy); end
    vectors++; if (pre_pulse !== 1'b0) begin miscompares++; $display("FAIL ideal_early_pulse got %b want 0", pre_pulse); end
    vectors++; if (cap_valid !== 1'b1) begin miscompares++; $display("FAIL ideal_valid got %b want 1", cap_valid); end
    vectors++; if (cap_err !== 1'b0) begin miscompares++; $display("FAIL ideal_id_error got %b want 0", cap_err); end
    vectors++; if (cap_seq !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ideal_seq got %h want deadbeef", cap_seq); end
    vectors++; if (cap_id !== 8'hA5) begin miscompares++; $display("FAIL ideal_id got %h want a5", cap_id); end
    vectors++; if (cap_busy !== 1'b0) begin miscompares++; $display("FAIL ideal_busy_e1440 got %b want 0", cap_busy); end
    vectors++; if (post_pulse !== 1'b0) begin miscompares++; $display("FAIL ideal_pulse_width got %b want 0", post_pulse); end
  endtask

  task automatic test_bad_id();
    send_line({8'h5A, 32'h0BADF00D}, 0, 0, 10'h200, 10'h040, 1440);
    finish_line();
    vectors++; if (cap_err !== 1'b1) begin miscompares++; $display("FAIL badid_id_error got %b want 1", cap_err); end
    vectors++; if (cap_valid !== 1'b0) begin miscompares++; $display("FAIL badid_valid got %b want 0", cap_valid); end
    vectors++; if (cap_id !== 8'h5A) begin miscompares++; $display("FAIL badid_id got %h want 5a", cap_id); end
    vectors++; if (cap_seq !== 32'hDEADBEEF) begin miscompares++; $display("FAIL badid_seq_held got %h want deadbeef", cap_seq); end
    vectors++; if (post_pulse !== 1'b0) begin miscompares++; $display("FAIL badid_pulse_width got %b want 0", post_pulse); end
  endtask

  task automatic test_noisy();
    send_line({8'hA5, 32'h00000001}, 8, 8, 10'h200, 10'h040, 1440);
    finish_line();
    vectors++; if (cap_valid !== 1'b1) begin miscompares++; $display("FAIL noisy_valid got %b want 1", cap_valid); end
    vectors++; if (cap_seq !== 32'h00000001) begin miscompares++; $display("FAIL noisy_seq got %h want 00000001", cap_seq); end
  endtask

  task automatic test_nine_votes();
    send_line({8'hA5, 32'h00000000}, 0, 9, 10'h200, 10'h040, 1440);
    finish_line();
    vectors++; if (cap_valid !== 1'b1) begin miscompares++; $display("FAIL nine_valid got %b want 1", cap_valid); end
    vectors++; if (cap_seq !== 32'h00000000) begin miscompares++; $display("FAIL nine_seq got %h want 00000000", cap_seq); end
  endtask

  task automatic test_threshold();
    send_line({8'hA5, 32'hC3A51E96}, 0, 0, 10'h3FF, 10'h1F6, 1440);
    finish_line();
    vectors++; if (cap_valid !== 1'b1) begin miscompares++; $display("FAIL thresh_valid got %b want 1", cap_valid); end
    vectors++; if (cap_seq !== 32'hC3A51E96) begin miscompares++; $display("FAIL thresh_seq got %h want c3a51e96", cap_seq); end
    vectors++; if (cap_id !== 8'hA5) begin miscompares++; $display("FAIL thresh_id got %h want a5", cap_id); end
  endtask

  task automatic test_abort();
    send_line({8'hA5, 32'hFFFFFFFF}, 0, 0, 10'h200, 10'h040, 700);
    @(negedge clk);
    enable    = 1'b0;
    sample_in = 10'h000;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
    vectors++; if ((valid | id_error) !== 1'b0) begin miscompares++; $display("FAIL abort_pulse got %b want 0", valid | id_error); end
    vectors++; if (sequence_out !== 32'hC3A51E96) begin miscompares++; $display("FAIL abort_seq_held got %h want c3a51e96", sequence_out); end
    send_line({8'hA5, 32'h12345678}, 0, 0, 10'h200, 10'h040, 1440);
    finish_line();
    vectors++; if (cap_valid !== 1'b1) begin miscompares++; $display("FAIL after_abort_valid got %b want 1", cap_valid); end
    vectors++; if (cap_seq !== 32'h12345678) begin miscompares++; $display("FAIL after_abort_seq got %h want 12345678", cap_seq); end
  endtask

  task automatic test_reset_mid();
    send_line({8'hA5, 32'h87654321}, 0, 0, 10'h200, 10'h040, 300);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (sequence_out !== 32'h0) begin miscompares++; $display("FAIL midrst_seq got %h want 00000000", sequence_out); end
    vectors++; if (id_out !== 8'h00) begin miscompares++; $display("FAIL midrst_id got %h want 00", id_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
    vectors++; if ((valid | id_error) !== 1'b0) begin miscompares++; $display("FAIL midrst_pulse got %b want 0", valid | id_error); end
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if ((valid | id_error | busy) !== 1'b0) begin miscompares++; $display("FAIL midrst_quiet got %b want 0", valid | id_error | busy); end
  endtask

  task automatic test_long_enable();
    int nvalid;
    int nboth;
    nvalid = 0;
    nboth  = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (valid) nvalid++;
      if (valid && id_error) nboth++;
      enable    = 1'b1;
      sample_in = sample_val({8'hA5, 32'hCAFEF00D}, i, 0, 0, 10'h200, 10'h040);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid) nvalid++;
      if (valid && id_error) nboth++;
      enable    = 1'b0;
      sample_in = 10'h000;
    end
    vectors++; if (nvalid !== 1) begin miscompares++; $display("FAIL long_valid_count got %0d want 1", nvalid); end
    vectors++; if (nboth !== 0) begin miscompares++; $display("FAIL long_both_pulses got %0d want 0", nboth); end
    vectors++; if (sequence_out !== 32'hCAFEF00D) begin miscompares++; $display("FAIL long_seq got %h want cafef00d", sequence_out); end
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    sample_in = 10'h000;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_ideal();
    test_bad_id();
    test_noisy();
    test_nine_votes();
    test_threshold();
    test_abort();
    test_reset_mid();
    test_long_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
